lcd_vram_writer: RTL and testbench

- Write side of the 14-bit x 4-bit LCD video RAM that the VGA scan-out reads.
- Accepts the Z88 LCD pixel stream one byte (8 pixels) at a time over a valid/ready handshake and splits each byte into two nibble writes.
- Advances a raster pointer {line[5:0], nibble[7:0]} through the 160x64-nibble (640x64 pixel) screen and flags frame completion.

---
 rtl/lcd_vram_writer.sv | 94 +++++++++
 tb/tb_lcd_vram_writer.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/lcd_vram_writer.sv
// lcd_vram_writer: splits the LCD pixel byte stream into nibble writes to the VGA video RAM
module lcd_vram_writer #(
    parameter int NIBBLES_PER_LINE = 160,
    parameter int LINES            = 64
) (
    input  logic        clk25,
    input  logic        reset_n,
    input  logic        lcdon,
    input  logic        sof,
    input  logic        px_valid,
    input  logic [7:0]  px_data,
    output logic        px_ready,
    output logic [13:0] vram_a,
    output logic [3:0]  vram_do,
    output logic        vram_we,
    output logic        frame_done
);

    typedef enum logic {IDLE, WR_LO} state_t;

    state_t      state_q, state_d;
    logic [5:0]  line_q, line_d;
    logic [7:0]  nib_q, nib_d;
    logic [3:0]  lo_q, lo_d;
    logic [13:0] vram_a_q, vram_a_d;
    logic [3:0]  vram_do_q, vram_do_d;
    logic        vram_we_q, vram_we_d;
    logic        frame_done_q, frame_done_d;

    logic last_nib, last_line, accept, kill;

    assign px_ready   = lcdon & ~sof & (state_q == IDLE);
    assign accept     = px_valid & px_ready;
    // A dark LCD behaves exactly like a start-of-frame held every cycle.
    assign kill       = sof | ~lcdon;
    assign last_nib   = nib_q == 8'(NIBBLES_PER_LINE - 1);
    assign last_line  = line_q == 6'(LINES - 1);

    assign vram_a     = vram_a_q;
    assign vram_do    = vram_do_q;
    assign vram_we    = vram_we_q;
    assign frame_done = frame_done_q;

    // Next-state: restart on sof/lcdon low, otherwise emit high nibble on accept then the latched low nibble.
    always_comb begin
        state_d      = state_q;
        line_d       = line_q;
        nib_d        = nib_q;
        lo_d         = lo_q;
        vram_a_d     = vram_a_q;
        vram_do_d    = vram_do_q;
        vram_we_d    = 1'b0;
        frame_done_d = 1'b0;
        if (kill) begin
            state_d = IDLE;
            line_d  = '0;
            nib_d   = '0;
            lo_d    = '0;
        end else if (state_q == WR_LO || accept) begin
            vram_a_d     = {line_q, nib_q};
            vram_do_d    = (state_q == WR_LO) ? lo_q : px_data[7:4];
            vram_we_d    = 1'b1;
            lo_d         = (state_q == WR_LO) ? lo_q : px_data[3:0];
            state_d      = (state_q == WR_LO) ? IDLE : WR_LO;
            nib_d        = last_nib ? 8'd0 : nib_q + 8'd1;
            line_d       = last_nib ? (last_line ? 6'd0 : line_q + 6'd1) : line_q;
            frame_done_d = last_nib & last_line;
        end
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clk25 or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            line_q       <= '0;
            nib_q        <= '0;
            lo_q         <= '0;
            vram_a_q     <= '0;
            vram_do_q    <= '0;
            vram_we_q    <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            line_q       <= line_d;
            nib_q        <= nib_d;
            lo_q         <= lo_d;
            vram_a_q     <= vram_a_d;
            vram_do_q    <= vram_do_d;
            vram_we_q    <= vram_we_d;
            frame_done_q <= frame_done_d;
        end
    end

endmodule

// File: tb/tb_lcd_vram_writer.sv
// tb_lcd_vram_writer: directed checks of the LCD-to-VRAM nibble writer
module tb_lcd_vram_writer;

    logic        clk25, reset_n, lcdon, sof, px_valid, px_ready, vram_we, frame_done;
    logic [7:0]  px_data;
    logic [13:0] vram_a;
    logic [3:0]  vram_do;
    int          checks, errors;

    lcd_vram_writer dut (
        .clk25(clk25), .reset_n(reset_n), .lcdon(lcdon), .sof(sof),
        .px_valid(px_valid), .px_data(px_data), .px_ready(px_ready),
        .vram_a(vram_a), .vram_do(vram_do), .vram_we(vram_we), .frame_done(frame_done)
    );

    initial clk25 = 1'b0;
    always #20 clk25 = ~clk25;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_wr(input string tag, input logic fd, input logic we,
                          input logic [13:0] a, input logic [3:0] d);
        chk(tag, {12'd0, frame_done, vram_we, vram_a, vram_do}, {12'd0, fd, we, a, d});
    endtask

    function automatic logic [13:0] addr_of(input int k);
        return {6'(k / 160), 8'(k % 160)};
    endfunction

    function automatic logic [7:0] frame_byte(input int i);
        return 8'(i) ^ 8'h5A;
    endfunction

    initial begin
        checks = 0; errors = 0;
        reset_n = 1'b0; lcdon = 1'b0; sof = 1'b0; px_valid = 1'b0; px_data = 8'h00;
        repeat (2) @(negedge clk25);
        chk_wr("reset_state", 1'b0, 1'b0, 14'h0000, 4'h0);
        chk("reset_ready", {31'd0, px_ready}, 32'd0);
        reset_n = 1'b1; lcdon = 1'b1; sof = 1'b1;
        #1 chk("sof_ready", {31'd0, px_ready}, 32'd0);

        // single byte 0xA5
        @(negedge clk25);
        sof = 1'b0; px_valid = 1'b1; px_data = 8'hA5;
        #1 chk("idle_ready", {31'd0, px_ready}, 32'd1);
        @(negedge clk25);
        chk_wr("a5_hi", 1'b0, 1'b1, 14'h0000, 4'hA);
        chk("a5_busy", {31'd0, px_ready}, 32'd0);
        px_valid = 1'b0; px_data = 8'hFF;
        @(negedge clk25);
        chk_wr("a5_lo", 1'b0, 1'b1, 14'h0001, 4'h5);
        chk("a5_ready_back", {31'd0, px_ready}, 32'd1);
        @(negedge clk25);
        chk_wr("a5_idle_hold", 1'b0, 1'b0, 14'h0001, 4'h5);

        // 80 back-to-back bytes fill line 0
        sof = 1'b1;
        @(negedge clk25);
        sof = 1'b0; px_valid = 1'b1; px_data = 8'd3;
        for (int i = 0; i < 80; i++) begin
            logic [7:0] d;
            d = px_data;
            @(negedge clk25);
            chk_wr("line_hi", 1'b0, 1'b1, addr_of(2 * i), d[7:4]);
            px_data = 8'(i * 7 + 10);
            @(negedge clk25);
            chk_wr("line_lo", 1'b0, 1'b1, addr_of(2 * i + 1), d[3:0]);
        end
        begin
            logic [7:0] d;
            d = px_data;
            @(negedge clk25);
            chk_wr("line1_start", 1'b0, 1'b1, {6'd1, 8'd0}, d[7:4]);
        end
        px_valid = 1'b0;
        @(negedge clk25);

        // full frame of 5120 bytes
        sof = 1'b1;
        @(negedge clk25);
        sof = 1'b0; px_valid = 1'b1; px_data = frame_byte(0);
        for (int i = 0; i < 5120; i++) begin
            @(negedge clk25);
            chk_wr("frame_hi", 1'b0, 1'b1, addr_of(2 * i), frame_byte(i) >> 4);
            px_data = frame_byte(i + 1);
            @(negedge clk25);
            chk_wr("frame_lo", i == 5119, 1'b1, addr_of(2 * i + 1), 4'(frame_byte(i)));
        end
        @(negedge clk25);
        chk_wr("frame_wrap_hi", 1'b0, 1'b1, 14'h0000, frame_byte(5120) >> 4);
        px_valid = 1'b0;
        @(negedge clk25);
        chk_wr("frame_wrap_lo", 1'b0, 1'b1, 14'h0001, 4'(frame_byte(5120)));

        // sof aborts the pending low nibble of 0x3C at 0x0010
        sof = 1'b1;
        @(negedge clk25);
        sof = 1'b0; px_valid = 1'b1; px_data = 8'h11;
        for (int j = 0; j < 16; j++) begin
            @(negedge clk25);
            if (j == 14) px_data = 8'h3C;
        end
        chk_wr("pre_abort", 1'b0, 1'b1, 14'h000F, 4'h1);
        @(negedge clk25);
        chk_wr("abort_hi", 1'b0, 1'b1, 14'h0010, 4'h3);
        sof = 1'b1; px_valid = 1'b0;
        #1 chk("abort_ready", {31'd0, px_ready}, 32'd0);
        @(negedge clk25);
        chk_wr("abort_no_lo", 1'b0, 1'b0, 14'h0010, 4'h3);
        sof = 1'b0; px_valid = 1'b1; px_data = 8'h96;
        @(negedge clk25);
        chk_wr("after_abort_hi", 1'b0, 1'b1, 14'h0000, 4'h9);
        px_valid = 1'b0;
        @(negedge clk25);
        chk_wr("after_abort_lo", 1'b0, 1'b1, 14'h0001, 4'h6);

        // lcdon dropped mid-line with px_valid held high
        px_valid = 1'b1; px_data = 8'h42;
        @(negedge clk25);
        chk_wr("lcd_hi", 1'b0, 1'b1, 14'h0002, 4'h4);
        @(negedge clk25);
        chk_wr("lcd_lo", 1'b0, 1'b1, 14'h0003, 4'h2);
        lcdon = 1'b0;
        #1 chk("lcdoff_ready", {31'd0, px_ready}, 32'd0);
        @(negedge clk25);
        chk("lcdoff_we1", {31'd0, vram_we}, 32'd0);
        @(negedge clk25);
        chk("lcdoff_we2", {31'd0, vram_we}, 32'd0);
        chk("lcdoff_ready2", {31'd0, px_ready}, 32'd0);
        lcdon = 1'b1;
        #1 chk("lcdon_ready", {31'd0, px_ready}, 32'd1);
        @(negedge clk25);
        chk_wr("lcdon_hi", 1'b0, 1'b1, 14'h0000, 4'h4);
        px_valid = 1'b0;
        @(negedge clk25);
        chk_wr("lcdon_lo", 1'b0, 1'b1, 14'h0001, 4'h2);

        // asynchronous reset during WR_LO
        px_valid = 1'b1; px_data = 8'hE7;
        @(negedge clk25);
        chk_wr("rst_pre_hi", 1'b0, 1'b1, 14'h0002, 4'hE);
        px_valid = 1'b0;
        #5 reset_n = 1'b0;
        #1 chk_wr("async_reset", 1'b0, 1'b0, 14'h0000, 4'h0);
        #5 reset_n = 1'b1;
        @(negedge clk25);
        chk_wr("post_reset1", 1'b0, 1'b0, 14'h0000, 4'h0);
        @(negedge clk25);
        chk_wr("post_reset2", 1'b0, 1'b0, 14'h0000, 4'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
